// File: rtl/fir4_stream_ctrl.sv
// fir4_stream_ctrl: valid/ready front end for a 4-tap unsigned averaging FIR with a FWFT output FIFO.
// Latency: result at FIFO head one edge after the 4th accept; backpressure reserves FIFO space for the pending sum. Macro: FIR4_ROUND_EN.
module fir4_stream_ctrl #(
  parameter int W         = 16,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_in_data,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [W+1:0]     o_out_sum,
  output logic [W-1:0]     o_out_avg,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_out_cnt
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_x0, r_x1, r_x2, r_x3;
  logic [1:0]       r_fill;
  logic             r_pend;
  logic [W+1:0]     r_mem_sum [OUT_DEPTH];
  logic [W-1:0]     r_mem_avg [OUT_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_fifo_cnt;
  logic [CNT_W-1:0] r_out_cnt;

  logic             w_acc, w_push, w_pop, w_flush_exit;
  logic [CW-1:0]    w_occ;
  logic [W+1:0]     w_sum, w_avg_full;
  logic [W-1:0]     w_avg;

  // Pending sum counts as occupied so the FIFO can never overflow.
  assign w_occ      = r_fifo_cnt + CW'(r_pend);
  assign o_in_ready = !i_flush && (r_state != S_FLUSH) && (w_occ < CW'(OUT_DEPTH));
  assign w_acc      = i_in_valid && o_in_ready;

  assign w_sum = {2'b00, r_x0} + {2'b00, r_x1} + {2'b00, r_x2} + {2'b00, r_x3};
`ifdef FIR4_ROUND_EN
  assign w_avg_full = (w_sum + (W+2)'(2)) >> 2;
`else
  assign w_avg_full = w_sum >> 2;
`endif
  assign w_avg = w_avg_full[W-1:0];

  assign w_push       = r_pend;
  assign w_pop        = o_out_valid && i_out_ready;
  assign w_flush_exit = (r_state == S_FLUSH) && !r_pend;

  assign o_out_valid = (r_fifo_cnt != '0);
  assign o_out_sum   = o_out_valid ? r_mem_sum[r_rd_ptr] : '0;
  assign o_out_avg   = o_out_valid ? r_mem_avg[r_rd_ptr] : '0;
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_cnt   = r_out_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = S_FILL;
      S_FILL: begin
        if (i_flush)                          w_state_nxt = S_FLUSH;
        else if (w_acc && (r_fill == 2'd2))   w_state_nxt = S_RUN;
      end
      S_RUN:   if (i_flush) w_state_nxt = S_FLUSH;
      S_FLUSH: if (!r_pend) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_x3    <= '0;
      r_fill  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Pend marks that the taps now hold a full window worth summing.
      r_pend  <= w_acc && (r_fill == 2'd3);
      if (w_flush_exit) begin
        r_x0   <= '0;
        r_x1   <= '0;
        r_x2   <= '0;
        r_x3   <= '0;
        r_fill <= '0;
      end else if (w_acc) begin
        r_x3 <= r_x2;
        r_x2 <= r_x1;
        r_x1 <= r_x0;
        r_x0 <= i_in_data;
        if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_out_cnt  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_mem_sum[i] <= '0;
        r_mem_avg[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_sum[r_wr_ptr] <= w_sum;
        r_mem_avg[r_wr_ptr] <= w_avg;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
        r_out_cnt           <= r_out_cnt + CNT_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fir4_stream_ctrl.sv
// Directed bench for fir4_stream_ctrl; expected averages follow the FIR4_ROUND_EN build.
module tb_fir4_stream_ctrl;
  localparam int W = 16;

`ifdef FIR4_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W+1:0]  out_sum;
  logic [W-1:0]  out_avg;
  logic          busy;
  logic [15:0]   out_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fir4_stream_ctrl #(.W(W), .OUT_DEPTH(2), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_flush(flush), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_sum(out_sum), .o_out_avg(out_avg), .o_busy(busy), .o_out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] trunc_v, input logic [31:0] round_v);
    return RND ? round_v : trunc_v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic pop(input string tag, input logic [31:0] exp_sum, input logic [31:0] exp_avg);
    int n;
    n = 0;
    out_ready = 1'b1;
    #1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"}, {14'd0, out_sum}, exp_sum);
    check({tag, "_avg"}, {16'd0, out_avg}, exp_avg);
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] got [$];
    int idx;
    int seen;

    // 1: reset state, then one window 1..4
    do_reset();
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   {14'd0, out_sum},   32'd0);
    check("rst_out_avg",   {16'd0, out_avg},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out_cnt",   {16'd0, out_cnt},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    check("t1_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_sum", {14'd0, out_sum}, 32'd10);
    check("t1_avg", {16'd0, out_avg}, pick(32'd2, 32'd3));
    check("t1_cnt", {16'd0, out_cnt}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("t1_single", {31'd0, out_valid}, 32'd0);
    check("t1_cnt_after", {16'd0, out_cnt}, 32'd1);

    // 2: warm-up only
    do_reset();
    send(16'd1); send(16'd2); send(16'd3);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("t2_no_out", seen, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_cnt", {16'd0, out_cnt}, 32'd0);

    // 3: stall with out_ready=0, then drain 1..8 in order
    do_reset();
    idx = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = (cyc >= 10);
      in_valid  = (idx < 8);
      in_data   = W'(idx + 1);
      #1;
      if (cyc == 9) begin
        check("t3_accepted", idx, 32'd5);
        check("t3_stalled", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) got.push_back({14'd0, out_sum});
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_count", got.size(), 32'd5);
    if (got.size() == 5) begin
      check("t3_s0", got[0], 32'd10);
      check("t3_s1", got[1], 32'd14);
      check("t3_s2", got[2], 32'd18);
      check("t3_s3", got[3], 32'd22);
      check("t3_s4", got[4], 32'd26);
    end
    check("t3_out_cnt", {16'd0, out_cnt}, 32'd5);

    // 4: full-scale samples
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'hFFFF);
    pop("t4", 32'h3FFFC, 32'hFFFF);

    // 5: flush with a colliding sample
    do_reset();
    send(16'd1); send(16'd2); send(16'd3); send(16'd4); send(16'd5);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd9;
    #1;
    check("t5_flush_blocks", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick(); tick();
    check("t5_cnt_kept", {16'd0, out_cnt}, 32'd2);
    check("t5_idle", {31'd0, busy}, 32'd0);
    pop("t5a", 32'd10, pick(32'd2, 32'd3));
    pop("t5b", 32'd14, pick(32'd3, 32'd4));
    send(16'd6); send(16'd7); send(16'd8);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("t5_warmup_quiet", seen, 32'd0);
    send(16'd9);
    pop("t5c", 32'd30, pick(32'd7, 32'd8));

    // 6: mid-stream reset with FIFO entry and pend set
    do_reset();
    send(16'd1); send(16'd2); send(16'd3); send(16'd4); send(16'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_cnt", {16'd0, out_cnt}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t6_pend_dropped", {31'd0, out_valid}, 32'd0);
    send(16'd2); send(16'd2); send(16'd2); send(16'd2);
    pop("t6", 32'd8, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
